// File: rtl/udma_lsu_bus_arb.sv
// Round-robin arbiter sharing one LSU memory port between N_REQ requesters.
// Responses are routed back in order through a small owner-ID FIFO.
module udma_lsu_bus_arb #(
  parameter int N_REQ   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [N_REQ-1:0]     s_req_i,
  input  logic [N_REQ-1:0]     s_we_i,
  input  logic [N_REQ*32-1:0]  s_addr_i,
  input  logic [N_REQ*32-1:0]  s_wdata_i,
  output logic [N_REQ-1:0]     s_gnt_o,
  output logic [N_REQ-1:0]     s_rvalid_o,
  output logic [31:0]          s_rdata_o,
  output logic                 m_req_o,
  input  logic                 m_gnt_i,
  output logic                 m_we_o,
  output logic [31:0]          m_addr_o,
  output logic [31:0]          m_data_o,
  input  logic                 m_valid_i,
  input  logic [31:0]          m_data_i,
  output logic                 err_o
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, BUS} state_e;
  typedef logic [IDW-1:0] id_t;
  typedef logic [CW-1:0]  cnt_t;

  state_e      state_q, state_d;
  id_t         ptr_q, ptr_d;
  id_t         owner_q, owner_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_data_q, m_data_d;
  cnt_t        cnt_q, cnt_d;
  logic        err_q, err_d;
  id_t         fifo_q [MAX_OUT];
  id_t         fifo_d [MAX_OUT];

  logic        hi_found;
  id_t         hi_idx, lo_idx, win_idx;
  logic [31:0] win_addr, win_data;
  logic        win_we;
  logic        can_sel, push, pop;
  cnt_t        wr_idx;

  // Winner = first requester at or above ptr; otherwise the lowest one below it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (s_req_i[i]) begin
        if (id_t'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = id_t'(i);
        end else begin
          lo_idx = id_t'(i);
        end
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    win_addr = '0;
    win_data = '0;
    win_we   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == id_t'(i)) begin
        win_addr = s_addr_i[32*i +: 32];
        win_data = s_wdata_i[32*i +: 32];
        win_we   = s_we_i[i];
      end
    end
  end

  assign can_sel = (state_q == IDLE) && en_i && (|s_req_i) && (cnt_q < cnt_t'(MAX_OUT));
  assign push    = m_req_q && m_gnt_i;
  assign pop     = m_valid_i && (cnt_q != '0);
  assign wr_idx  = cnt_q - cnt_t'(pop);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    m_req_d  = m_req_q;
    m_we_d   = m_we_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    if (state_q == IDLE) begin
      if (can_sel) begin
        state_d  = BUS;
        owner_d  = win_idx;
        m_req_d  = 1'b1;
        m_we_d   = win_we;
        m_addr_d = win_addr;
        m_data_d = win_data;
      end
    end else if (m_gnt_i) begin
      state_d = IDLE;
      m_req_d = 1'b0;
      ptr_d   = (owner_q == id_t'(N_REQ - 1)) ? '0 : owner_q + id_t'(1);
    end

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + cnt_t'(1);
    else if (pop && !push) cnt_d = cnt_q - cnt_t'(1);

    err_d = err_q | (m_valid_i && (cnt_q == '0));
  end

  // Head always sits at slot 0; a pop shifts everything down one slot.
  always_comb begin
    fifo_d = fifo_q;
    if (pop) begin
      for (int i = 0; i < MAX_OUT - 1; i++) fifo_d[i] = fifo_q[i+1];
    end
    for (int i = 0; i < MAX_OUT; i++) begin
      if (push && (cnt_t'(i) == wr_idx)) fifo_d[i] = owner_q;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      m_req_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      m_req_q  <= m_req_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // NOTE: FIFO storage needs no reset; cnt_q alone decides which slots are valid.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  always_comb begin
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s_gnt_o[i]    = push && (owner_q == id_t'(i));
      s_rvalid_o[i] = pop && (fifo_q[0] == id_t'(i));
    end
  end

  assign s_rdata_o = m_data_i;
  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_data_o  = m_data_q;
  assign err_o     = err_q;

endmodule
